// File: rtl/tile_out_change_logger.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tile_out_change_logger: logs synchronised uo_out changes into a show-ahead
// FIFO; define TILE_LOG_TIMESTAMP_EN for per-entry timestamps.  Rev 1.0
// ---------------------------------------------------------------------------
module tile_out_change_logger #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int TS_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        tile_out,
   input  logic                     en,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic [TS_W-1:0]          rd_ts,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] s1, s2, baseline;
   logic              prime_stage, primed;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic              changed, push_req, pop, push, ovf_set;

   assign empty    = (count == '0);
   assign full     = (count == DEPTH_CNT);
   assign changed  = primed && (s2 != baseline);
   assign push_req = changed && en;
   assign pop      = rd_en && !empty;
   assign push     = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;

   // Baseline latches s1 (the value s2 takes on this edge) while priming,
   // so the power-up level is absorbed rather than reported as a change.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1          <= '0;
         s2          <= '0;
         baseline    <= '0;
         prime_stage <= 1'b0;
         primed      <= 1'b0;
      end else begin
         s1 <= tile_out;
         s2 <= s1;
         if (!primed) begin
            prime_stage <= 1'b1;
            if (prime_stage) begin
               primed   <= 1'b1;
               baseline <= s1;
            end
         end else if (changed) begin
            baseline <= s2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (ovf_set)      overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem_data[wr_ptr] <= s2;
   end

   assign rd_data = empty ? '0 : mem_data[rd_ptr];

`ifdef TILE_LOG_TIMESTAMP_EN
   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] mem_ts [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) ts <= '0;
      else        ts <= ts + TS_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem_ts[wr_ptr] <= ts;
   end

   assign rd_ts = empty ? '0 : mem_ts[rd_ptr];
`else
   assign rd_ts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_out_change_logger.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tile_out_change_logger: scoreboard bench, directed change vectors. Rev 1.0
// ---------------------------------------------------------------------------
module tb_tile_out_change_logger;

   logic       clk = 1'b0;
   logic       rst_n, en, rd_en, clr_ovf;
   logic [7:0] tile_out;
   logic [7:0] rd_data, rd_ts;
   logic       empty, full, overflow;
   logic [3:0] count;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] t;
   } ent_t;
   ent_t exp_q[$];
   ent_t mon_e;

   tile_out_change_logger #(.DATA_W(8), .DEPTH(8), .TS_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tile_out (tile_out),
      .en       (en),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_ts    (rd_ts),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   // Edges since reset release; equals the timestamp counter after each edge.
   always @(posedge clk) begin
      if (!rst_n) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_ts(input int n);
`ifdef TILE_LOG_TIMESTAMP_EN
      logic [31:0] v;
      v = n;
      return v[7:0];
`else
      return 8'h00;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Change applied now lands in the FIFO three edges later, stamped with
   // the counter value held just before that edge.
   task automatic change(input logic [7:0] v, input bit expect_push);
      tile_out = v;
      if (expect_push) exp_q.push_back('{d: v, t: exp_ts(edge_n + 2)});
   endtask

   task automatic drain(input int n);
      rd_en = 1'b1;
      tick(n);
      rd_en = 1'b0;
   endtask

   // Monitor: a pop is committed at the next edge; compare the head now.
   always @(negedge clk) begin
      if (rst_n && rd_en && !empty) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got %0h, expected no entry", rd_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pop_data", {24'h0, rd_data}, {24'h0, mon_e.d});
            chk("pop_ts", {24'h0, rd_ts}, {24'h0, mon_e.t});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; en = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0; tile_out = 8'hA5;
      tick(3);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_ts", rd_ts, 0);
      rst_n = 1'b1;
      tick(10);
      chk("prime_empty", empty, 1);
      chk("prime_count", count, 0);

      // Single change and its latency
      change(8'h3C, 1);
      tick(2);
      chk("lat_empty_k1", empty, 1);
      tick(1);
      chk("lat_empty_k2", empty, 0);
      chk("lat_count", count, 1);
      drain(1);
      chk("single_empty", empty, 1);

      // Fill and overflow
      for (int v = 1; v <= 9; v++) begin
         change(8'(v), v <= 8);
         tick(3);
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, 8);
      chk("fill_ovf", overflow, 1);
      drain(8);
      chk("drain_empty", empty, 1);
      chk("drain_ovf_sticky", overflow, 1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      chk("clr_ovf", overflow, 0);

      // Push and pop together on a full FIFO
      for (int v = 8'h41; v <= 8'h48; v++) begin
         change(8'(v), 1);
         tick(3);
      end
      chk("sim_pre_full", full, 1);
      change(8'h50, 1);
      tick(2);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      chk("sim_full_count", count, 8);
      chk("sim_full_ovf", overflow, 0);
      drain(8);
      chk("sim_drain_empty", empty, 1);

      // Push and pop together on an empty FIFO
      change(8'h60, 1);
      tick(2);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      chk("sim_empty_count", count, 1);
      drain(1);

      // Enable gating
      en = 1'b0;
      change(8'h10, 0);
      tick(3);
      change(8'h20, 0);
      tick(3);
      en = 1'b1;
      tick(5);
      chk("gate_empty", empty, 1);
      chk("gate_count", count, 0);
      change(8'h30, 1);
      tick(3);
      chk("gate_count_after", count, 1);
      drain(1);

      // Pointer wrap over many push/pop pairs
      for (int i = 0; i < 20; i++) begin
         change(8'(8'h80 + i), 1);
         tick(3);
         drain(1);
      end
      chk("wrap_empty", empty, 1);

      // Reset with entries queued
      for (int i = 0; i < 3; i++) begin
         change(8'(8'hC1 + i), 0);
         tick(3);
      end
      chk("mid_count", count, 3);
      chk("mid_head", rd_data, 8'hC1);
      rst_n = 1'b0;
      tick(1);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_ovf", overflow, 0);
      chk("mid_rst_rd_data", rd_data, 0);
      rst_n = 1'b1;
      tick(10);
      chk("reprime_empty", empty, 1);
      change(8'hD7, 1);
      tick(3);
      chk("reprime_count", count, 1);
      drain(1);

      tick(2);
      chk("sb_leftover", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
